// File: rtl/speedpong_pkg.sv
// Shared types and constants for the speedPong input path.
package speedpong_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        HELD,
        ARM_RELEASE
    } debounce_state_t;

    localparam logic BTN_RELEASED_LVL = 1'b1;

    // Debounced level: the qualified state, not the candidate being armed.
    function automatic logic state_is_pressed(debounce_state_t s);
        return (s == HELD) || (s == ARM_RELEASE);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button levels in, debounced levels and edge strobes out.
interface button_conditioner_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] pressed;
    logic [NUM_BTNS-1:0] press_pulse;
    logic [NUM_BTNS-1:0] release_pulse;
    logic                any_pressed;

    modport master (
        output btn_raw,
        input  pressed, press_pulse, release_pulse, any_pressed
    );

    modport slave (
        input  btn_raw,
        output pressed, press_pulse, release_pulse, any_pressed
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, qualification FSM with counter, edge strobes.
module debounce_channel
    import speedpong_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            s1_q, s2_q;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            press_pulse_q, press_pulse_d;
    logic            release_pulse_q, release_pulse_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= BTN_RELEASED_LVL;
            s2_q <= BTN_RELEASED_LVL;
        end else begin
            s1_q <= btn_raw_i;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= RELEASED;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    // Any disagreeing sample drops straight back to the settled state: no partial credit.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s2_q != BTN_RELEASED_LVL) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ARM_PRESS: begin
                if (s2_q == BTN_RELEASED_LVL) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d       = HELD;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (s2_q == BTN_RELEASED_LVL) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ARM_RELEASE: begin
                if (s2_q != BTN_RELEASED_LVL) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d         = RELEASED;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign pressed_o       = state_is_pressed(state_q);
    assign press_pulse_o   = press_pulse_q;
    assign release_pulse_o = release_pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces NUM_BTNS active-low buttons into clean active-high levels and strobes.
module button_conditioner
    import speedpong_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    button_conditioner_if.slave bus
);

    logic [NUM_BTNS-1:0] pressed_w;
    logic [NUM_BTNS-1:0] press_pulse_w;
    logic [NUM_BTNS-1:0] release_pulse_w;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .btn_raw_i       (bus.btn_raw[g]),
            .pressed_o       (pressed_w[g]),
            .press_pulse_o   (press_pulse_w[g]),
            .release_pulse_o (release_pulse_w[g])
        );
    end

    assign bus.pressed       = pressed_w;
    assign bus.press_pulse   = press_pulse_w;
    assign bus.release_pulse = release_pulse_w;
    assign bus.any_pressed   = |pressed_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulses queued at stimulus time, matched against DUT strobes each cycle.
module tb_button_conditioner;

    localparam int NB  = 4;
    localparam int DB  = 4;
    localparam int LAT = DB + 2;

    typedef struct {
        int at;
        int ch;
        bit is_press;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    button_conditioner_if #(.NUM_BTNS(NB)) bus ();

    button_conditioner #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int ch, input bit is_press, input int at);
        exp_t e;
        e.at = at;
        e.ch = ch;
        e.is_press = is_press;
        sbq.push_back(e);
    endtask

    // Every strobe must be expected and every expected strobe must show up on its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            logic [NB-1:0] exp_p, exp_r;
            exp_p = '0;
            exp_r = '0;
            foreach (sbq[i]) begin
                if (sbq[i].at == cyc) begin
                    if (sbq[i].is_press) exp_p[sbq[i].ch] = 1'b1;
                    else                 exp_r[sbq[i].ch] = 1'b1;
                end
            end
            for (int ch = 0; ch < NB; ch++) begin
                if (bus.press_pulse[ch] || exp_p[ch]) begin
                    chk($sformatf("press_pulse%0d", ch), bus.press_pulse[ch], exp_p[ch]);
                    if (exp_p[ch]) chk($sformatf("pressed_on_press%0d", ch), bus.pressed[ch], 1);
                end
                if (bus.release_pulse[ch] || exp_r[ch]) begin
                    chk($sformatf("release_pulse%0d", ch), bus.release_pulse[ch], exp_r[ch]);
                    if (exp_r[ch]) chk($sformatf("pressed_on_rel%0d", ch), bus.pressed[ch], 0);
                end
            end
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) sbq.delete(i);
            end
        end
    end

    initial begin
        int c;
        bus.btn_raw = '1;
        wait_edges(3);
        chk("rst_pressed", bus.pressed, 0);
        chk("rst_press_pulse", bus.press_pulse, 0);
        chk("rst_release_pulse", bus.release_pulse, 0);
        chk("rst_any", bus.any_pressed, 0);
        reset = 1'b0;
        wait_edges(4);

        // clean press on channel 0
        bus.btn_raw[0] = 1'b0;
        c = cyc;
        expect_pulse(0, 1, c + LAT);
        wait_edges(LAT - 1);
        chk("clean_early", bus.pressed, 4'b0000);
        wait_edges(1);
        chk("clean_lvl", bus.pressed, 4'b0001);
        chk("clean_pulse", bus.press_pulse, 4'b0001);
        chk("clean_any", bus.any_pressed, 1);
        wait_edges(1);
        chk("clean_pulse_end", bus.press_pulse, 4'b0000);

        // bounce on channel 1: low 2, high 1, then low steady
        bus.btn_raw[1] = 1'b0;
        wait_edges(2);
        bus.btn_raw[1] = 1'b1;
        wait_edges(1);
        bus.btn_raw[1] = 1'b0;
        c = cyc;
        expect_pulse(1, 1, c + LAT);
        wait_edges(LAT - 1);
        chk("bounce_early", bus.pressed, 4'b0001);
        wait_edges(3);
        chk("bounce_lvl", bus.pressed, 4'b0011);

        // short glitch on channel 2: three low samples only
        bus.btn_raw[2] = 1'b0;
        wait_edges(3);
        bus.btn_raw[2] = 1'b1;
        wait_edges(10);
        chk("glitch_lvl", bus.pressed, 4'b0011);

        // release channel 0
        bus.btn_raw[0] = 1'b1;
        c = cyc;
        expect_pulse(0, 0, c + LAT);
        wait_edges(LAT);
        chk("rel_lvl", bus.pressed, 4'b0010);
        chk("rel_pulse", bus.release_pulse, 4'b0001);
        wait_edges(1);
        chk("rel_pulse_end", bus.release_pulse, 4'b0000);

        bus.btn_raw[1] = 1'b1;
        expect_pulse(1, 0, cyc + LAT);
        wait_edges(LAT + 2);
        chk("all_released", bus.any_pressed, 0);

        // simultaneous press on every channel
        bus.btn_raw = '0;
        c = cyc;
        for (int ch = 0; ch < NB; ch++) expect_pulse(ch, 1, c + LAT);
        wait_edges(LAT);
        chk("sim_pulse", bus.press_pulse, 4'b1111);
        chk("sim_any", bus.any_pressed, 1);
        wait_edges(2);

        // reset while held, buttons stay low
        reset = 1'b1;
        #1;
        chk("rst_hold_pressed", bus.pressed, 0);
        chk("rst_hold_rel", bus.release_pulse, 0);
        chk("rst_hold_any", bus.any_pressed, 0);
        wait_edges(2);
        reset = 1'b0;
        c = cyc;
        for (int ch = 0; ch < NB; ch++) expect_pulse(ch, 1, c + LAT);
        wait_edges(LAT - 1);
        chk("rearm_early", bus.pressed, 4'b0000);
        wait_edges(1);
        chk("rearm_lvl", bus.pressed, 4'b1111);
        chk("rearm_pulse3", bus.press_pulse[3], 1);
        wait_edges(2);

        bus.btn_raw = '1;
        c = cyc;
        for (int ch = 0; ch < NB; ch++) expect_pulse(ch, 0, c + LAT);
        wait_edges(LAT + 3);
        chk("final_lvl", bus.pressed, 4'b0000);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
